// File: rtl/qam_p2s_rx.sv
// QAM receive P2S stage: buffers 2-bit symbol decisions (I in bit 1, Q in bit 0)
// in a small FIFO and re-serialises them I-then-Q, one bit per enable_cntr tick.
module qam_p2s_rx #(
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          enable_cntr,
  input  logic          sym_valid,
  input  logic [1:0]    sym_in,
  output logic          adat_ki,
  output logic          bit_valid,
  output logic          data_change,
  output logic          fifo_full,
  output logic [AW:0]   fifo_level,
  output logic          overflow,
  output logic          underrun
);

  typedef enum logic {
    IDLE   = 1'b0,
    SEND_Q = 1'b1
  } state_e;

  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

  logic [1:0]    mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   count_q, count_d;
  state_e        state_q, state_d;
  logic          adat_q, adat_d;
  logic          shadow_q, shadow_d;
  logic          bit_valid_q, bit_valid_d;
  logic          data_change_q, data_change_d;
  logic          started_q, started_d;
  logic          overflow_q, overflow_d;
  logic          underrun_q, underrun_d;
  logic          pop, push;
  logic [1:0]    head;

  assign head = mem_q[rd_ptr_q];

  // A full FIFO still accepts a write when the same cycle pops the head.
  assign push       = sym_valid && ((count_q != DEPTH_C) || pop);
  assign count_d    = count_q + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
  assign overflow_d = overflow_q | (sym_valid & ~push);

  // NOTE: storage has no reset; pointers and count alone decide which entries are live.
  always_ff @(posedge clock) begin
    if (push) mem_q[wr_ptr_q] <= sym_in;
  end

  always_comb begin
    // NOTE: every output of this block gets a default first, so no latches are inferred.
    state_d       = state_q;
    adat_d        = adat_q;
    shadow_d      = shadow_q;
    bit_valid_d   = 1'b0;
    data_change_d = 1'b0;
    started_d     = started_q;
    underrun_d    = underrun_q;
    pop           = 1'b0;
    case (state_q)
      IDLE: begin
        if (enable_cntr) begin
          if (count_q != '0) begin
            pop           = 1'b1;
            adat_d        = head[1];
            shadow_d      = head[0];
            bit_valid_d   = 1'b1;
            data_change_d = 1'b1;
            started_d     = 1'b1;
            state_d       = SEND_Q;
          end else if (started_q) begin
            underrun_d = 1'b1;
          end
        end
      end
      SEND_Q: begin
        if (enable_cntr) begin
          adat_d      = shadow_q;
          bit_valid_d = 1'b1;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      state_q       <= IDLE;
      adat_q        <= 1'b0;
      shadow_q      <= 1'b0;
      bit_valid_q   <= 1'b0;
      data_change_q <= 1'b0;
      started_q     <= 1'b0;
      overflow_q    <= 1'b0;
      underrun_q    <= 1'b0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q       <= count_d;
      state_q       <= state_d;
      adat_q        <= adat_d;
      shadow_q      <= shadow_d;
      bit_valid_q   <= bit_valid_d;
      data_change_q <= data_change_d;
      started_q     <= started_d;
      overflow_q    <= overflow_d;
      underrun_q    <= underrun_d;
    end
  end

  assign adat_ki     = adat_q;
  assign bit_valid   = bit_valid_q;
  assign data_change = data_change_q;
  assign fifo_full   = (count_q == DEPTH_C);
  assign fifo_level  = count_q;
  assign overflow    = overflow_q;
  assign underrun    = underrun_q;

endmodule

// File: tb/tb_qam_p2s_rx.sv
// Self-checking bench for qam_p2s_rx: directed scenarios plus a random stream,
// every cycle compared against a queue-based model of the symbol/bit flow.
module tb_qam_p2s_rx;

  localparam int DEPTH = 4;
  localparam int AW    = 2;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          enable_cntr = 1'b0;
  logic          sym_valid = 1'b0;
  logic [1:0]    sym_in = 2'b00;
  logic          adat_ki, bit_valid, data_change, fifo_full, overflow, underrun;
  logic [AW:0]   fifo_level;

  qam_p2s_rx #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clock       (clock),
    .reset       (reset),
    .enable_cntr (enable_cntr),
    .sym_valid   (sym_valid),
    .sym_in      (sym_in),
    .adat_ki     (adat_ki),
    .bit_valid   (bit_valid),
    .data_change (data_change),
    .fifo_full   (fifo_full),
    .fifo_level  (fifo_level),
    .overflow    (overflow),
    .underrun    (underrun)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_fail   = 0;

  // Model: queued symbols, plus the bits of the current symbol not yet sent.
  logic [1:0] mq[$];
  bit         pend[$];
  bit         m_adat, m_bv, m_dc, m_ovf, m_und, m_started;

  // Observed-output captures.
  bit cap_bits[$];
  bit cap_dc[$];
  int bv_cnt, ones_cnt;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    pend.delete();
    m_adat = 0; m_bv = 0; m_dc = 0; m_ovf = 0; m_und = 0; m_started = 0;
  endtask

  task automatic model_edge(input bit en, input bit sv, input logic [1:0] sym);
    logic [1:0] w;
    m_bv = 0;
    m_dc = 0;
    if (en) begin
      if (pend.size() > 0) begin
        m_adat = pend.pop_front();
        m_bv   = 1;
      end else if (mq.size() > 0) begin
        w = mq.pop_front();
        m_adat = w[1];
        pend.push_back(w[0]);
        m_bv = 1;
        m_dc = 1;
        m_started = 1;
      end else if (m_started) begin
        m_und = 1;
      end
    end
    if (sv) begin
      if (mq.size() < DEPTH) mq.push_back(sym);
      else m_ovf = 1;
    end
  endtask

  task automatic compare_all(input string tag);
    check({tag, ".adat_ki"},     32'(adat_ki),     32'(m_adat));
    check({tag, ".bit_valid"},   32'(bit_valid),   32'(m_bv));
    check({tag, ".data_change"}, 32'(data_change), 32'(m_dc));
    check({tag, ".fifo_level"},  32'(fifo_level),  32'(mq.size()));
    check({tag, ".fifo_full"},   32'(fifo_full),   32'(mq.size() == DEPTH));
    check({tag, ".overflow"},    32'(overflow),    32'(m_ovf));
    check({tag, ".underrun"},    32'(underrun),    32'(m_und));
  endtask

  task automatic step(input string tag, input bit en, input bit sv, input logic [1:0] sym);
    enable_cntr = en;
    sym_valid   = sv;
    sym_in      = sym;
    @(posedge clock);
    model_edge(en, sv, sym);
    #1;
    compare_all(tag);
    if (bit_valid) begin
      cap_bits.push_back(adat_ki);
      cap_dc.push_back(data_change);
      bv_cnt++;
    end
    if (adat_ki) ones_cnt++;
    enable_cntr = 1'b0;
    sym_valid   = 1'b0;
  endtask

  task automatic do_reset(input string tag);
    reset = 1'b1;
    #1;
    model_reset();
    compare_all(tag);
    @(negedge clock);
    reset = 1'b0;
    cap_bits.delete();
    cap_dc.delete();
    bv_cnt   = 0;
    ones_cnt = 0;
  endtask

  initial begin
    logic [1:0] t1_syms [3];
    logic [1:0] t2_syms [5];
    bit         t2_bits [8];
    logic [1:0] rnd_syms[$];
    logic [1:0] s;

    // 1: reset values, then three symbols with enable tied high.
    @(negedge clock);
    do_reset("t1_reset");
    t1_syms = '{2'b10, 2'b01, 2'b11};
    for (int i = 0; i < 3; i++) step("t1_wr", 1, 1, t1_syms[i]);
    for (int i = 0; i < 5; i++) step("t1_run", 1, 0, 2'b00);
    check("t1_nbits", 32'(cap_bits.size()), 32'd6);
    for (int i = 0; i < 6 && i < cap_bits.size(); i++) begin
      check($sformatf("t1_bit%0d", i), 32'(cap_bits[i]), 32'(t1_syms[i/2][1 - (i % 2)]));
      check($sformatf("t1_dc%0d", i),  32'(cap_dc[i]),   32'((i % 2) == 0));
    end
    check("t1_level", 32'(fifo_level), 32'd0);
    check("t1_underrun", 32'(underrun), 32'd1);

    // 2: fill past DEPTH with the serialiser paused, then drain.
    do_reset("t2_reset");
    t2_syms = '{2'b00, 2'b01, 2'b10, 2'b11, 2'b00};
    for (int i = 0; i < 5; i++) begin
      step("t2_wr", 0, 1, t2_syms[i]);
      if (i == 3) check("t2_full_after4", 32'(fifo_full), 32'd1);
      if (i == 3) check("t2_ovf_after4", 32'(overflow), 32'd0);
    end
    check("t2_overflow", 32'(overflow), 32'd1);
    for (int i = 0; i < 12; i++) step("t2_drain", 1, 0, 2'b00);
    t2_bits = '{0, 0, 0, 1, 1, 0, 1, 1};
    check("t2_nbits", 32'(cap_bits.size()), 32'd8);
    for (int i = 0; i < 8 && i < cap_bits.size(); i++)
      check($sformatf("t2_bit%0d", i), 32'(cap_bits[i]), 32'(t2_bits[i]));

    // 3: full FIFO, write coincident with an IDLE tick pop.
    do_reset("t3_reset");
    for (int i = 0; i < DEPTH; i++) step("t3_fill", 0, 1, 2'(i));
    check("t3_full", 32'(fifo_full), 32'd1);
    step("t3_popwr", 1, 1, 2'b11);
    check("t3_ovf", 32'(overflow), 32'd0);
    check("t3_level", 32'(fifo_level), 32'd4);
    for (int i = 0; i < 10; i++) step("t3_drain", 1, 0, 2'b00);
    check("t3_nbits", 32'(cap_bits.size()), 32'd10);

    // 4: slow pacing tick every 4th clock.
    do_reset("t4_reset");
    step("t4_wr", 0, 1, 2'b11);
    step("t4_wr", 0, 1, 2'b00);
    bv_cnt = 0;
    ones_cnt = 0;
    for (int i = 0; i < 20; i++) step("t4_run", (i % 4) == 3, 0, 2'b00);
    check("t4_bv_pulses", 32'(bv_cnt), 32'd4);
    check("t4_ones_clocks", 32'(ones_cnt), 32'd8);
    check("t4_final_adat", 32'(adat_ki), 32'd0);

    // 5: asynchronous reset while in SEND_Q with two symbols buffered.
    do_reset("t5_reset0");
    step("t5_wr", 0, 1, 2'b11);
    step("t5_wr", 0, 1, 2'b10);
    step("t5_wr", 0, 1, 2'b01);
    step("t5_pop", 1, 0, 2'b00);
    check("t5_pre_level", 32'(fifo_level), 32'd2);
    check("t5_pre_adat", 32'(adat_ki), 32'd1);
    #2;
    do_reset("t5_async");
    for (int i = 0; i < 6; i++) step("t5_idle", 1, 0, 2'b00);
    check("t5_no_bv", 32'(bv_cnt), 32'd0);
    step("t5_wr2", 0, 1, 2'b01);
    step("t5_out", 1, 0, 2'b00);
    step("t5_out", 1, 0, 2'b00);
    check("t5_nbits", 32'(cap_bits.size()), 32'd2);
    if (cap_bits.size() == 2) begin
      check("t5_bitI", 32'(cap_bits[0]), 32'd0);
      check("t5_bitQ", 32'(cap_bits[1]), 32'd1);
    end

    // 6: random rate-matched stream, pointers wrap many times.
    do_reset("t6_reset");
    for (int c = 0; c < 64 * 4 + 8; c++) begin
      if ((c % 4) == 0 && rnd_syms.size() < 64) begin
        s = 2'($urandom);
        rnd_syms.push_back(s);
        step("t6_run", (c % 2) == 1, 1, s);
      end else begin
        step("t6_run", (c % 2) == 1, 0, 2'b00);
      end
    end
    check("t6_nbits", 32'(cap_bits.size()), 32'd128);
    for (int i = 0; i < 128 && i < cap_bits.size(); i++)
      check($sformatf("t6_bit%0d", i), 32'(cap_bits[i]), 32'(rnd_syms[i/2][1 - (i % 2)]));
    check("t6_overflow", 32'(overflow), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/qam_p2s_rx.md
Name: qam_p2s_rx

Overview:
Receive-side counterpart of the transmit serial-to-parallel stage. It accepts 2-bit QAM symbol decisions: I sign in bit 1, Q sign in bit 0, exactly the pair the transmitter's S2P stage emits. It buffers them in a small FIFO and re-serialises them into a bitstream paced by the main_cntr enable tick. The recovered serial stream feeds a downstream bit-error checker placed alongside Adat_Gen.

Parameters:
DEPTH, 4, FIFO depth in symbols; power of two, minimum 2.
AW, 2, FIFO address width; must equal log2(DEPTH).

Ports:
clock  input  1  system clock, all state on rising edge
reset  input  1  asynchronous, active-high; clears all state
enable_cntr  input  1  one-clock pacing tick from main_cntr; one output bit per tick
sym_valid  input  1  symbol strobe; one symbol accepted per cycle when high
sym_in  input  2  [1]=I sign bit, [0]=Q sign bit; sampled when sym_valid=1
adat_ki  output  1  recovered serial bit, registered, held between ticks
bit_valid  output  1  one-clock pulse coincident with each new adat_ki value
data_change  output  1  one-clock pulse on the first bit (I bit) of each symbol
fifo_full  output  1  FIFO occupancy == DEPTH
fifo_level  output  AW+1  current FIFO occupancy, 0..DEPTH
overflow  output  1  sticky; symbol dropped because FIFO full
underrun  output  1  sticky; tick found FIFO empty after streaming began

Behaviour:
- Reset values: adat_ki=0, bit_valid=0, data_change=0, fifo_level=0, fifo_full=0, overflow=0, underrun=0, state=IDLE, pointers=0, started=0.
- Reset asserted mid-operation discards buffered symbols and any half-sent symbol immediately.
- FIFO:
  - Circular buffer with AW-bit read/write pointers that wrap modulo DEPTH, plus an AW+1-bit count.
  - Write occurs when sym_valid=1 and (count<DEPTH or a pop occurs in the same cycle).
  - Full with simultaneous pop: write accepted, count unchanged.
  - Full without pop: symbol dropped, overflow set; overflow clears only on reset.
  - Empty with simultaneous write: no bypass; the new symbol becomes visible next cycle.
- Serialiser FSM, two states:
  - IDLE, enable_cntr=1, FIFO non-empty: pop the head word w; adat_ki<=w[1]; hold w[0] in the shadow register; bit_valid<=1; data_change<=1; started<=1; go to SEND_Q.
  - IDLE, enable_cntr=1, FIFO empty: no output change. If started=1, set underrun (sticky).
  - IDLE, enable_cntr=0: hold.
  - SEND_Q, enable_cntr=1: adat_ki<=shadow; bit_valid<=1; data_change stays 0; go to IDLE.
  - SEND_Q, enable_cntr=0: hold.
- Throughput: one bit per enable_cntr tick. A continuous stream needs one symbol per two ticks.
- Bit order per symbol: I bit first, then Q bit. This is the inverse of the S2P shift-in order.
- Latency: a symbol written in cycle t can be popped at the first enable_cntr tick in cycle ≥ t+1 while in IDLE. adat_ki updates on that same clock edge.
- bit_valid and data_change are high for exactly one clock each, never for two consecutive clocks unless enable_cntr is high on consecutive clocks.
- enable_cntr held permanently high (freq_prescale=0) is legal: one bit per clock.

Test Plan:
1. Reset, then write 2'b10, 2'b01, 2'b11 with enable_cntr tied high -> adat_ki sequence 1,0,0,1,1,1 on consecutive clocks; data_change pulses on bits 1, 3, 5; fifo_level returns to 0; underrun=1 on the tick after the last bit.
2. With enable_cntr=0, write 5 symbols 2'b00,01,10,11,00 (DEPTH=4) -> fifo_full=1 after the 4th write; 5th symbol dropped; overflow=1; subsequent ticks emit 0,0,0,1,1,0,1,1 only.
3. FIFO full, assert sym_valid on the same cycle as an IDLE-state tick pop -> write accepted; overflow stays 0; fifo_level stays 4.
4. enable_cntr pulsing every 4th clock, two symbols 2'b11, 2'b00 -> adat_ki changes only on tick edges, holds 1 for 8 clocks then 0; bit_valid exactly 4 pulses.
5. Assert reset while in SEND_Q with 2 symbols buffered -> all outputs return to reset values asynchronously; no further bit_valid after release until a new write.
6. Pointer wrap: stream 64 random symbols with DEPTH=4 and enable_cntr every 2nd clock, writer rate-matched -> serial output equals the input symbols flattened I-then-Q; overflow=0.
